// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register numbers, writable-field masks, bit positions
// and exception codes used by the CP0 register file and its timer.
package cp0_regfile_pkg;

  localparam int CP0_REG_W = 5;

  localparam logic [CP0_REG_W-1:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [CP0_REG_W-1:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [CP0_REG_W-1:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [CP0_REG_W-1:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [CP0_REG_W-1:0] CP0_REG_EPC     = 5'd14;

  localparam logic REG_WB = 1'b1;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

  localparam int STATUS_EXL      = 1;
  localparam int CAUSE_BD        = 31;
  localparam int CAUSE_EXC_LSB   = 2;
  localparam int CAUSE_IP_HW_LSB = 10;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exc_code_e;

  // Merge software-writable bits of new_val into old_val.
  function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Pipeline-side bundle of the CP0 register file: MTC0 write, MFC0 read,
// exception/ERET commit, hardware interrupts and the exported CP0 state.
interface cp0_regfile_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int HW_INT_WIDTH = 6
);
  import cp0_regfile_pkg::*;

  logic                    wb_cp0;
  logic [CP0_REG_W-1:0]    wb_cp0_write_addr;
  logic [DATA_WIDTH-1:0]   wb_cp0_write;
  logic [CP0_REG_W-1:0]    rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [HW_INT_WIDTH-1:0] hw_int;
  logic                    exc_valid;
  logic [4:0]              exc_code;
  logic [ADDR_WIDTH-1:0]   exc_epc;
  logic                    exc_in_delay_slot;
  logic                    eret;
  logic [DATA_WIDTH-1:0]   cp0_status;
  logic [DATA_WIDTH-1:0]   cp0_cause;
  logic [ADDR_WIDTH-1:0]   cp0_epc;
  logic                    timer_int;

  modport master (
    output wb_cp0, wb_cp0_write_addr, wb_cp0_write, rd_addr, hw_int,
           exc_valid, exc_code, exc_epc, exc_in_delay_slot, eret,
    input  rd_data, cp0_status, cp0_cause, cp0_epc, timer_int
  );

  modport slave (
    input  wb_cp0, wb_cp0_write_addr, wb_cp0_write, rd_addr, hw_int,
           exc_valid, exc_code, exc_epc, exc_in_delay_slot, eret,
    output rd_data, cp0_status, cp0_cause, cp0_epc, timer_int
  );

endinterface

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: free-running Count, Compare, and a sticky
// timer_int flag that only a Compare write clears.
module cp0_regfile_timer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  count_we_i,
  input  logic                  compare_we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic [DATA_WIDTH-1:0] compare_o,
  output logic                  timer_int_o
);

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic                  timer_int_q, timer_int_d;

  // Next-state: Compare==0 disables the match; a Compare write beats a match.
  always_comb begin
    count_d     = count_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else begin
      count_d = count_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
    if (compare_we_i) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != {DATA_WIDTH{1'b0}})) begin
      timer_int_d = 1'b1;
    end else begin
      timer_int_d = timer_int_q;
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= {DATA_WIDTH{1'b0}};
      compare_q   <= {DATA_WIDTH{1'b0}};
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC with MTC0, exception entry and ERET
// commit, hardware interrupt sampling, MFC0 read mux, and the Count/Compare timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int HW_INT_WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  cp0_regfile_if.slave bus
);

  localparam int CAUSE_IP_HW_MSB = CAUSE_IP_HW_LSB + HW_INT_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] EPC_DS_OFFSET = ADDR_WIDTH'(4);

  logic [HW_INT_WIDTH-1:0] hw_sync1_q, hw_sync2_q;
  logic [DATA_WIDTH-1:0]   status_q, status_d;
  logic [DATA_WIDTH-1:0]   cause_q, cause_d;
  logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
  logic [DATA_WIDTH-1:0]   count_s, compare_s;
  logic                    timer_int_s;
  logic                    mtc0_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;

  assign mtc0_s = (bus.wb_cp0 == REG_WB);

  cp0_regfile_timer #(.DATA_WIDTH(DATA_WIDTH)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_we_i   (mtc0_s && (bus.wb_cp0_write_addr == CP0_REG_COUNT)),
    .compare_we_i (mtc0_s && (bus.wb_cp0_write_addr == CP0_REG_COMPARE)),
    .wdata_i      (bus.wb_cp0_write),
    .count_o      (count_s),
    .compare_o    (compare_s),
    .timer_int_o  (timer_int_s)
  );

  // Next-state: MTC0 first, then exception/ERET override the fields they own.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    cause_d[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] = hw_sync2_q;
    cause_d[CAUSE_IP_HW_MSB] = hw_sync2_q[HW_INT_WIDTH-1] | timer_int_s;
    if (mtc0_s) begin
      case (bus.wb_cp0_write_addr)
        CP0_REG_STATUS: status_d = apply_wmask(status_q, bus.wb_cp0_write, STATUS_WMASK);
        CP0_REG_CAUSE:  cause_d  = apply_wmask(cause_d, bus.wb_cp0_write, CAUSE_WMASK);
        CP0_REG_EPC:    epc_d    = bus.wb_cp0_write[ADDR_WIDTH-1:0];
        default: begin
          status_d = status_q;
        end
      endcase
    end else begin
      status_d = status_q;
    end
    if (bus.exc_valid) begin
      epc_d = epc_q;
      if (!status_q[STATUS_EXL]) begin
        epc_d = bus.exc_in_delay_slot ? (bus.exc_epc - EPC_DS_OFFSET) : bus.exc_epc;
        cause_d[CAUSE_BD] = bus.exc_in_delay_slot;
      end else begin
        cause_d[CAUSE_BD] = cause_q[CAUSE_BD];
      end
      cause_d[CAUSE_EXC_LSB +: 5] = bus.exc_code;
      status_d[STATUS_EXL]        = 1'b1;
    end else if (bus.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end else begin
      cause_d[CAUSE_BD] = cause_q[CAUSE_BD];
    end
  end

  // Architectural CP0 registers and the two-flop interrupt synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hw_sync1_q <= {HW_INT_WIDTH{1'b0}};
      hw_sync2_q <= {HW_INT_WIDTH{1'b0}};
      status_q   <= {DATA_WIDTH{1'b0}};
      cause_q    <= {DATA_WIDTH{1'b0}};
      epc_q      <= {ADDR_WIDTH{1'b0}};
    end else begin
      hw_sync1_q <= bus.hw_int;
      hw_sync2_q <= hw_sync1_q;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
    end
  end

  // MFC0 read mux on current register state.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    case (bus.rd_addr)
      CP0_REG_COUNT:   rd_data_s = count_s;
      CP0_REG_COMPARE: rd_data_s = compare_s;
      CP0_REG_STATUS:  rd_data_s = status_q;
      CP0_REG_CAUSE:   rd_data_s = cause_q;
      CP0_REG_EPC:     rd_data_s = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, epc_q};
      default:         rd_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign bus.rd_data    = rd_data_s;
  assign bus.cp0_status = status_q;
  assign bus.cp0_cause  = cause_q;
  assign bus.cp0_epc    = epc_q;
  assign bus.timer_int  = timer_int_s;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed-vector bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  int   waited;
  bit   seen;

  cp0_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .HW_INT_WIDTH(6)) bus ();

  cp0_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .HW_INT_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_cp0            = 1'b1;
    bus.wb_cp0_write_addr = addr;
    bus.wb_cp0_write      = data;
    step();
    bus.wb_cp0 = 1'b0;
  endtask

  task automatic mfc0(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rd_addr = addr;
    #1;
    check_val(tag, bus.rd_data, exp);
  endtask

  task automatic take_exc(input logic [4:0] code, input logic [15:0] epc, input logic ds);
    bus.exc_valid         = 1'b1;
    bus.exc_code          = code;
    bus.exc_epc           = epc;
    bus.exc_in_delay_slot = ds;
    step();
    bus.exc_valid = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.wb_cp0 = 1'b0; bus.wb_cp0_write_addr = 5'd0; bus.wb_cp0_write = 32'd0;
    bus.rd_addr = 5'd0; bus.hw_int = 6'd0; bus.exc_valid = 1'b0; bus.exc_code = 5'd0;
    bus.exc_epc = 16'd0; bus.exc_in_delay_slot = 1'b0; bus.eret = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state and idle counting
    repeat (5) step();
    mfc0("count_after_5", CP0_REG_COUNT, 32'd5);
    check_val("status_rst", bus.cp0_status, 32'h0);
    check_val("cause_rst", bus.cp0_cause, 32'h0);
    check_val("epc_rst", {16'h0, bus.cp0_epc}, 32'h0);
    check_val("timer_rst", {31'h0, bus.timer_int}, 32'h0);

    // Writable masks
    mtc0(CP0_REG_STATUS, 32'hFFFF_FFFF);
    check_val("status_mask", bus.cp0_status, 32'h0000_FF03);
    mtc0(CP0_REG_CAUSE, 32'hFFFF_FFFF);
    check_val("cause_mask", bus.cp0_cause, 32'h00C0_0300);
    mfc0("mfc0_cause", CP0_REG_CAUSE, 32'h00C0_0300);
    mtc0(CP0_REG_EPC, 32'h1234_ABCD);
    mfc0("mfc0_epc_zext", CP0_REG_EPC, 32'h0000_ABCD);
    mtc0(5'd5, 32'hDEAD_BEEF);
    mfc0("unmapped_reg", 5'd5, 32'h0);

    // Count wrap; Compare==0 never fires
    mtc0(CP0_REG_COUNT, 32'hFFFF_FFFF);
    mfc0("count_load", CP0_REG_COUNT, 32'hFFFF_FFFF);
    step();
    mfc0("count_wrap", CP0_REG_COUNT, 32'h0);
    step();
    check_val("timer_cmp0", {31'h0, bus.timer_int}, 32'h0);

    // Count/Compare match
    mtc0(CP0_REG_COMPARE, 32'd20);
    mtc0(CP0_REG_COUNT, 32'd10);
    check_val("timer_pre", {31'h0, bus.timer_int}, 32'h0);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 30) begin
      step();
      waited++;
      seen = bus.timer_int;
    end
    check_val("timer_latency", waited, 32'd11);
    mfc0("count_at_timer", CP0_REG_COUNT, 32'd21);
    step();
    check_val("cause_ip7_timer", bus.cp0_cause, 32'h00C0_8300);
    mtc0(CP0_REG_COMPARE, 32'd100);
    check_val("timer_clear", {31'h0, bus.timer_int}, 32'h0);
    mtc0(CP0_REG_COMPARE, 32'd0);

    // Exception entry, EXL, delay slot
    mtc0(CP0_REG_STATUS, 32'h0);
    mtc0(CP0_REG_CAUSE, 32'h0);
    check_val("cause_cleared", bus.cp0_cause, 32'h0);
    take_exc(5'h08, 16'h0104, 1'b1);
    check_val("exc1_epc", {16'h0, bus.cp0_epc}, 32'h0000_0100);
    check_val("exc1_cause", bus.cp0_cause, 32'h8000_0020);
    check_val("exc1_status", bus.cp0_status, 32'h0000_0002);
    take_exc(5'h0C, 16'h0200, 1'b0);
    check_val("exc2_epc_hold", {16'h0, bus.cp0_epc}, 32'h0000_0100);
    check_val("exc2_cause", bus.cp0_cause, 32'h8000_0030);
    do_eret();
    check_val("eret1_status", bus.cp0_status, 32'h0);
    check_val("eret1_epc", {16'h0, bus.cp0_epc}, 32'h0000_0100);

    // exc + eret + MTC0 Status in one cycle
    bus.eret = 1'b1;
    bus.wb_cp0 = 1'b1; bus.wb_cp0_write_addr = CP0_REG_STATUS; bus.wb_cp0_write = 32'h0;
    take_exc(5'h04, 16'h0300, 1'b0);
    bus.eret = 1'b0;
    bus.wb_cp0 = 1'b0;
    check_val("prio_status", bus.cp0_status, 32'h0000_0002);
    check_val("prio_epc", {16'h0, bus.cp0_epc}, 32'h0000_0300);
    check_val("prio_cause", bus.cp0_cause, 32'h0000_0010);
    do_eret();
    check_val("eret2_status", bus.cp0_status, 32'h0);
    check_val("eret2_epc", {16'h0, bus.cp0_epc}, 32'h0000_0300);
    take_exc(5'h00, 16'h0002, 1'b1);
    check_val("epc_ds_wrap", {16'h0, bus.cp0_epc}, 32'h0000_FFFE);
    check_val("cause_ds_wrap", bus.cp0_cause, 32'h8000_0000);
    do_eret();

    // Hardware interrupt synchronizer latency
    bus.hw_int = 6'b000100;
    step();
    check_val("hw_int_c1", {31'h0, bus.cp0_cause[12]}, 32'h0);
    step();
    check_val("hw_int_c2", {31'h0, bus.cp0_cause[12]}, 32'h0);
    step();
    check_val("hw_int_c3", {31'h0, bus.cp0_cause[12]}, 32'h1);

    // Reset mid-operation
    mtc0(CP0_REG_STATUS, 32'h0000_FF01);
    rst_n = 1'b0;
    bus.hw_int = 6'd0;
    step();
    mfc0("rst_count", CP0_REG_COUNT, 32'h0);
    check_val("rst_status", bus.cp0_status, 32'h0);
    check_val("rst_cause", bus.cp0_cause, 32'h0);
    check_val("rst_epc", {16'h0, bus.cp0_epc}, 32'h0);
    check_val("rst_timer", {31'h0, bus.timer_int}, 32'h0);
    rst_n = 1'b1;
    step();
    mfc0("count_after_rst", CP0_REG_COUNT, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
